ofifo_align: RTL and testbench

OFIFO_ALIGN -- requirements
Module: ofifo_align

---
 rtl/ofifo_align.sv | 103 ++++++++++
 tb/tb_ofifo_align.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ofifo_align.sv
// Output FIFO that collects per-lane partial sums written in any skew and pops
// them back as aligned rows. Optional sticky error flags under OFIFO_ERR_EN.
module ofifo_align #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [col*psum_bw-1:0]   in,
  input  logic [col-1:0]           wr,
  input  logic                     rd,
  output logic [col*psum_bw-1:0]   out,
  output logic                     o_full,
  output logic                     o_ready,
  output logic                     o_valid,
  output logic [1:0]               o_err
);

  localparam int AW = $clog2(depth);

  // Handshake: a row pops on an edge where rd=1 and o_valid=1 (both seen
  // before the edge); wr[c] is per lane and lands while the lane is not full,
  // or while full if a pop frees a slot on the same edge.
  logic [psum_bw-1:0] mem_q    [col][depth];
  logic [AW:0]        wr_ptr_q [col];
  logic [AW:0]        wr_ptr_d [col];
  logic [AW:0]        rd_ptr_q [col];
  logic [AW:0]        rd_ptr_d [col];
  logic [col*psum_bw-1:0] out_q, out_d;
  logic [col-1:0]     full, empty, wr_acc;
  logic               pop;

  always_comb begin
    full  = '0;
    empty = '0;
    for (int c = 0; c < col; c++) begin
      empty[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
      full[c]  = (wr_ptr_q[c][AW] != rd_ptr_q[c][AW]) &&
                 (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]);
    end
  end

  assign o_valid = ~|empty;
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign pop     = rd & o_valid;
  assign out     = out_q;

  always_comb begin
    out_d  = out_q;
    wr_acc = '0;
    for (int c = 0; c < col; c++) begin
      wr_acc[c]   = wr[c] & (~full[c] | pop);
      wr_ptr_d[c] = wr_ptr_q[c] + (AW+1)'(wr_acc[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + (AW+1)'(pop);
      if (pop) out_d[c*psum_bw +: psum_bw] = mem_q[c][rd_ptr_q[c][AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < col; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
      out_q <= '0;
    end else begin
      for (int c = 0; c < col; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
      end
      out_q <= out_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (!reset && wr_acc[c]) mem_q[c][wr_ptr_q[c][AW-1:0]] <= in[c*psum_bw +: psum_bw];
    end
  end

`ifdef OFIFO_ERR_EN
  logic [1:0] err_q, err_d;

  always_comb begin
    err_d    = err_q;
    err_d[0] = err_q[0] | (|(wr & full & ~{col{pop}}));
    err_d[1] = err_q[1] | (rd & ~o_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 2'b00;
    else       err_q <= err_d;
  end

  assign o_err = err_q;
`else
  assign o_err = 2'b00;
`endif

endmodule

// File: tb/tb_ofifo_align.sv
// Scoreboard bench for ofifo_align: per-lane count model predicts flags,
// popped rows are queued as expected results and compared after each pop.
module tb_ofifo_align;

  localparam int COL = 8;
  localparam int PBW = 16;
  localparam int DEP = 64;
  localparam int W   = COL*PBW;

  logic           clk;
  logic           reset;
  logic [W-1:0]   in;
  logic [COL-1:0] wr;
  logic           rd;
  logic [W-1:0]   out;
  logic           o_full, o_ready, o_valid;
  logic [1:0]     o_err;

  ofifo_align #(.col(COL), .psum_bw(PBW), .depth(DEP)) dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
    .o_full(o_full), .o_ready(o_ready), .o_valid(o_valid), .o_err(o_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and model state
  logic [W-1:0]   exp_q[$];
  logic [PBW-1:0] m_mem [COL][DEP];
  int             m_wcnt [COL];
  int             m_rcnt;
  logic [W-1:0]   last_out;
  logic [1:0]     exp_err;
  int             n_checks;
  int             n_err;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic m_valid();
    for (int c = 0; c < COL; c++) if (m_wcnt[c] - m_rcnt == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_full();
    for (int c = 0; c < COL; c++) if (m_wcnt[c] - m_rcnt == DEP) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_err();
`ifdef OFIFO_ERR_EN
    return exp_err;
`else
    return 2'b00;
`endif
  endfunction

  // driver: one clock of stimulus with pre-edge and post-edge checks
  task automatic cycle(input logic [COL-1:0] w, input logic [W-1:0] d, input logic r, input string tag);
    logic         pop_m;
    logic [W-1:0] row, exp;
    int           cnt;
    @(negedge clk);
    wr = w; in = d; rd = r;
    #1;
    check({tag, "_valid_pre"}, W'(o_valid), W'(m_valid()));
    check({tag, "_full_pre"},  W'(o_full),  W'(m_full()));
    pop_m = r && m_valid();
    if (pop_m) begin
      row = '0;
      for (int c = 0; c < COL; c++) row[c*PBW +: PBW] = m_mem[c][m_rcnt % DEP];
      exp_q.push_back(row);
    end
    if (r && !pop_m) exp_err[1] = 1'b1;
    for (int c = 0; c < COL; c++) begin
      cnt = m_wcnt[c] - m_rcnt;
      if (w[c] && (cnt < DEP || pop_m)) begin
        m_mem[c][m_wcnt[c] % DEP] = d[c*PBW +: PBW];
        m_wcnt[c]++;
      end else if (w[c]) begin
        exp_err[0] = 1'b1;
      end
    end
    if (pop_m) m_rcnt++;
    @(posedge clk);
    #1;
    if (pop_m) begin
      exp = exp_q.pop_front();
      last_out = exp;
      check({tag, "_out_pop"}, out, exp);
    end else begin
      check({tag, "_out_hold"}, out, last_out);
    end
    check({tag, "_valid"}, W'(o_valid), W'(m_valid()));
    check({tag, "_full"},  W'(o_full),  W'(m_full()));
    check({tag, "_ready"}, W'(o_ready), W'(!m_full()));
    check({tag, "_err"},   W'(o_err),   W'(m_err()));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1; wr = '1; rd = 1'b1; in = '1;
    @(posedge clk);
    #1;
    for (int c = 0; c < COL; c++) m_wcnt[c] = 0;
    m_rcnt = 0; last_out = '0; exp_err = 2'b00;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0; wr = '0; rd = 1'b0; in = '0;
    check({tag, "_out"},   out, '0);
    check({tag, "_valid"}, W'(o_valid), W'(0));
    check({tag, "_full"},  W'(o_full),  W'(0));
    check({tag, "_ready"}, W'(o_ready), W'(1));
    check({tag, "_err"},   W'(o_err),   W'(0));
  endtask

  function automatic logic [W-1:0] row_of(input logic [PBW-1:0] base);
    logic [W-1:0] r;
    for (int c = 0; c < COL; c++) r[c*PBW +: PBW] = base + PBW'(c);
    return r;
  endfunction

  initial begin
    n_checks = 0; n_err = 0;
    reset = 1'b1; wr = '0; rd = 1'b0; in = '0;
    for (int c = 0; c < COL; c++) m_wcnt[c] = 0;
    m_rcnt = 0; last_out = '0; exp_err = 2'b00;
    repeat (2) @(posedge clk);
    do_reset("rst");

    // aligned write of all lanes, then one pop
    cycle('1, row_of(16'h0100), 1'b0, "align_wr");
    cycle('0, '0, 1'b1, "align_rd");

    // skewed writes: lane c at cycle c
    for (int c = 0; c < COL; c++) begin
      logic [W-1:0] d;
      d = '0;
      d[c*PBW +: PBW] = 16'h0200 + PBW'(c);
      cycle(COL'(1) << c, d, 1'b0, "skew_wr");
    end
    cycle('0, '0, 1'b1, "skew_rd");

    // fill lane 0, overflow it, fill the rest, then drain in order
    for (int i = 0; i < DEP; i++) cycle(COL'(1), W'(i), 1'b0, "fill0");
    cycle(COL'(1), W'(16'hDEAD), 1'b0, "ovf");
    for (int i = 0; i < DEP; i++) cycle(~COL'(1), {COL{PBW'(16'h0300 + i)}}, 1'b0, "fillr");
    for (int i = 0; i < DEP; i++) cycle('0, '0, 1'b1, "drain");

    // full lanes with simultaneous write and pop
    do_reset("rst2");
    for (int i = 0; i < DEP; i++) cycle('1, {COL{PBW'(16'h0400 + i)}}, 1'b0, "fullall");
    cycle(COL'(1), W'(16'hBEEF), 1'b1, "wr_rd_full");
    for (int i = 0; i < DEP; i++) cycle('0, '0, 1'b1, "drain2");

    // pop request on empty
    do_reset("rst3");
    cycle('0, '0, 1'b1, "rd_empty");
    cycle('0, '0, 1'b0, "idle");

    // long random stream across pointer wrap, then reset mid-stream
    do_reset("rst4");
    for (int i = 0; i < 6*DEP; i++) begin
      logic [COL-1:0] w;
      logic [W-1:0]   d;
      w = ($urandom_range(0, 3) == 0) ? COL'($urandom_range(0, 255)) : '1;
      for (int c = 0; c < COL; c++) d[c*PBW +: PBW] = PBW'($urandom_range(0, 65535));
      cycle(w, d, 1'($urandom_range(0, 1)), "stream");
    end
    do_reset("rst_mid");
    cycle('0, '0, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
